spi_cs_ctrl: RTL and testbench

- Parametrised multi-slave chip-select controller for the SPI path, and the successor to the single-line slave-select block.
- Drives NUM_SLAVES active-low select lines, one per peripheral (ACL, future Pmods).
- Enforces programmable CS-to-SCLK setup, SCLK-to-CS hold and minimum CS-high gap, and tells the SPI master when it may start clocking.
- Sits between the top-level transaction sequencer and the SPI master/interface.

---
 rtl/spi_cs_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_cs_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_ctrl.sv
// spi_cs_ctrl: multi-slave SPI chip-select sequencer with CS setup, hold and minimum-gap timing.
// Define CS_TIMEOUT_EN to add a watchdog that ends a stalled ACTIVE phase through the normal hold/gap path.
module spi_cs_ctrl #(
    parameter int NUM_SLAVES  = 4,
    parameter int SEL_W       = 2,
    parameter int SETUP_CYC   = 2,
    parameter int HOLD_CYC    = 2,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmit,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  done,
    output logic [NUM_SLAVES-1:0] ss_n,
    output logic                  xfer_go,
    output logic                  busy,
    output logic                  sel_err,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HOLD,
        GAP
    } state_t;

    localparam int                    SEL_LW    = SEL_W + 1;
    localparam logic [CNT_W-1:0]      SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]      HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]      GAP_LD    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [SEL_LW-1:0]     SEL_LIMIT = SEL_LW'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] SS_ONE    = NUM_SLAVES'(1);
    localparam longint                CNT_MAX   = (longint'(1) << CNT_W) - 1;

    // Every counter preload must fit in cnt and every select must be addressable by sel.
    localparam bit CFG_OK = (NUM_SLAVES >= 1) && (NUM_SLAVES <= 16) &&
                            ((longint'(1) << SEL_W) >= NUM_SLAVES) &&
                            (SETUP_CYC >= 1) && (HOLD_CYC >= 1) && (GAP_CYC >= 1) &&
                            (TIMEOUT_CYC >= 1) &&
                            (SETUP_CYC <= CNT_MAX) && (HOLD_CYC <= CNT_MAX) &&
                            (GAP_CYC <= CNT_MAX) && (TIMEOUT_CYC <= CNT_MAX);

`ifdef CS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

    state_t                  state;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_d;
    logic [SEL_W-1:0]        sel_q;
    logic [SEL_W-1:0]        sel_q_d;
    logic [NUM_SLAVES-1:0]   ss_n_d;
    logic                    xfer_go_d;
    logic                    sel_err_d;
`ifdef CS_TIMEOUT_EN
    logic                    timeout_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            ss_n    <= '1;
            xfer_go <= 1'b0;
            busy    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            sel_q   <= sel_q_d;
            ss_n    <= ss_n_d;
            xfer_go <= xfer_go_d;
            busy    <= (state_d != IDLE);
            sel_err <= sel_err_d;
        end
    end

`ifdef CS_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // In ACTIVE the shared counter doubles as the watchdog, counting up from zero.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sel_q_d   = sel_q;
        ss_n_d    = ss_n;
        xfer_go_d = 1'b0;
        sel_err_d = 1'b0;
`ifdef CS_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (transmit) begin
                    if ({1'b0, sel} < SEL_LIMIT) begin
                        sel_q_d = sel;
                        ss_n_d  = ~(SS_ONE << sel);
                        cnt_d   = SETUP_LD;
                        state_d = SETUP;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    xfer_go_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACTIVE;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            ACTIVE: begin
                if (done) begin
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end
`ifdef CS_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = HOLD_LD;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
`endif
            end
            HOLD: begin
                if (cnt == '0) begin
                    ss_n_d  = '1;
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                ss_n_d  = '1;
                cnt_d   = '0;
            end
        endcase
    end

    // Structural guarantees: legal configuration, one select at most, and it matches the latched index.
    a_cfg_ok: assert property (@(posedge clk) CFG_OK);

    a_one_select: assert property (@(posedge clk) disable iff (rst) $onehot0(~ss_n));

    a_select_matches: assert property (@(posedge clk) disable iff (rst)
        (ss_n != '1) |-> (ss_n == ~(SS_ONE << sel_q)));

    a_busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
        busy == (state != IDLE));

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// tb_spi_cs_ctrl: randomized scoreboard bench for spi_cs_ctrl, one DUT at nominal timing and one at minimum (1/1/1) timing.
// Expected select/busy/go/error/timeout events are derived from transfer timing arithmetic and matched by per-DUT monitors.
`timescale 1ns/1ps
module tb_spi_cs_ctrl;

    localparam int NS    = 3;
    localparam int T_CYC = 8;
`ifdef CS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum int {EV_SS, EV_BUSY, EV_GO, EV_ERR, EV_TO} evKind_t;
    typedef struct {
        evKind_t kind;
        int      cyc;
        int      val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       transmit [2];
    logic [1:0] sel      [2];
    logic       done     [2];
    logic [2:0] ss_n     [2];
    logic       xfer_go  [2];
    logic       busy     [2];
    logic       sel_err  [2];
    logic       timeout  [2];

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    bit  scoreOn = 1'b0;
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_cs_ctrl #(
            .NUM_SLAVES (NS),
            .SEL_W      (2),
            .SETUP_CYC  (g == 0 ? 2 : 1),
            .HOLD_CYC   (g == 0 ? 2 : 1),
            .GAP_CYC    (g == 0 ? 4 : 1),
            .TIMEOUT_CYC(T_CYC),
            .CNT_W      (8)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .transmit(transmit[g]),
            .sel     (sel[g]),
            .done    (done[g]),
            .ss_n    (ss_n[g]),
            .xfer_go (xfer_go[g]),
            .busy    (busy[g]),
            .sel_err (sel_err[g]),
            .timeout (timeout[g])
        );
    end

    function automatic int setupOf(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int holdOf(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int gapOf(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushEv(int d, evKind_t k, int c, int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Each observed output event consumes the oldest expectation for that DUT.
    task automatic matchEv(int d, evKind_t k, int v);
        ev_t e;
        int  n;
        checks++;
        n = (d == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            errors++;
            $display("[TB] FAIL dut%0d event: got %s@%0d val %0d, expected no event", d, k.name(), cyc, v);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.kind != k || e.cyc != cyc || e.val != v) begin
            errors++;
            $display("[TB] FAIL dut%0d event: got %s@%0d val %0d, expected %s@%0d val %0d",
                     d, k.name(), cyc, v, e.kind.name(), e.cyc, e.val);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [2:0] prevSs;
        logic       prevBusy;
        always @(negedge clk) begin
            if (scoreOn) begin
                if (ss_n[g] !== prevSs)    matchEv(g, EV_SS, int'(ss_n[g]));
                if (busy[g] !== prevBusy)  matchEv(g, EV_BUSY, int'(busy[g]));
                if (xfer_go[g] !== 1'b0)   matchEv(g, EV_GO, int'(xfer_go[g]));
                if (sel_err[g] !== 1'b0)   matchEv(g, EV_ERR, int'(sel_err[g]));
                if (timeout[g] !== 1'b0)   matchEv(g, EV_TO, int'(timeout[g]));
            end
            prevSs   <= ss_n[g];
            prevBusy <= busy[g];
        end
    end

    task automatic checkOutput(string tag, int d, logic [2:0] expSs, logic expBusy, logic expGo);
        chk($sformatf("%s dut%0d ss_n", tag, d), 32'(ss_n[d]), 32'(expSs));
        chk($sformatf("%s dut%0d busy", tag, d), 32'(busy[d]), 32'(expBusy));
        chk($sformatf("%s dut%0d xfer_go", tag, d), 32'(xfer_go[d]), 32'(expGo));
        chk($sformatf("%s dut%0d sel_err", tag, d), 32'(sel_err[d]), 32'h0);
        chk($sformatf("%s dut%0d timeout", tag, d), 32'(timeout[d]), 32'h0);
    endtask

    // Transfer timeline for transmit sampled at edge k and completion at edge m:
    // select falls at k, go at k+SETUP, select rises at m+HOLD, busy drops at m+HOLD+GAP.
    task automatic applyStimulus(int d, int nTrans);
        int         s, h, g, k, m, dl, r, sv;
        bit         toMode, holdHigh;
        logic [2:0] exp3;
        s = setupOf(d);
        h = holdOf(d);
        g = gapOf(d);
        for (int t = 0; t < nTrans; t++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                repeat ($urandom_range(1, 3)) begin
                    transmit[d] = 1'b0;
                    sel[d]      = 2'($urandom_range(0, 3));
                    done[d]     = 1'($urandom_range(0, 1));
                    tick();
                end
            end else if (r == 2) begin
                transmit[d] = 1'b1;
                sel[d]      = 2'd3;
                done[d]     = 1'($urandom_range(0, 1));
                pushEv(d, EV_ERR, cyc + 1, 1);
                tick();
                transmit[d] = 1'b0;
            end else begin
                sv       = $urandom_range(0, NS - 1);
                k        = cyc + 1;
                toMode   = TO_EN && ($urandom_range(0, 3) == 0);
                holdHigh = ($urandom_range(0, 2) == 0);
                if (toMode) begin
                    m = k + s + T_CYC;
                end else begin
                    dl = TO_EN ? $urandom_range(1, T_CYC) : $urandom_range(1, 6);
                    if ($urandom_range(0, 4) == 0) dl = 1;
                    if (TO_EN && $urandom_range(0, 4) == 0) dl = T_CYC;
                    m = k + s + dl;
                end
                exp3 = ~(3'b001 << sv);
                pushEv(d, EV_SS, k, int'(exp3));
                pushEv(d, EV_BUSY, k, 1);
                pushEv(d, EV_GO, k + s, 1);
                if (toMode) pushEv(d, EV_TO, m, 1);
                pushEv(d, EV_SS, m + h, 7);
                pushEv(d, EV_BUSY, m + h + g, 0);
                transmit[d] = 1'b1;
                sel[d]      = 2'(sv);
                done[d]     = 1'($urandom_range(0, 1));
                tick();
                for (int e = k + 1; e <= m + h + g; e++) begin
                    transmit[d] = holdHigh ? 1'b1 : 1'($urandom_range(0, 1));
                    sel[d]      = 2'($urandom_range(0, 3));
                    if (e == m && !toMode)      done[d] = 1'b1;
                    else if (e > k + s && e <= m) done[d] = 1'b0;
                    else                        done[d] = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        transmit[d] = 1'b0;
        done[d]     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            transmit[d] = 1'b0;
            sel[d]      = 2'd0;
            done[d]     = 1'b0;
        end
        repeat (3) tick();
        checkOutput("por", 0, 3'b111, 1'b0, 1'b0);
        checkOutput("por", 1, 3'b111, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        transmit[0] = 1'b1;
        sel[0]      = 2'd1;
        transmit[1] = 1'b1;
        sel[1]      = 2'd2;
        tick();
        transmit[0] = 1'b0;
        transmit[1] = 1'b0;
        repeat (4) tick();
        checkOutput("active", 0, 3'b101, 1'b1, 1'b0);
        checkOutput("active", 1, 3'b011, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("midreset", 0, 3'b111, 1'b0, 1'b0);
        checkOutput("midreset", 1, 3'b111, 1'b0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        scoreOn = 1'b1;
        fork
            applyStimulus(0, 40);
            applyStimulus(1, 40);
        join
        repeat (3) tick();
        chk("dut0 queue drained", 32'(q0.size()), 32'h0);
        chk("dut1 queue drained", 32'(q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
